// File: rtl/interrupt_interface.sv
// ---------------------------------------------------------------------------
// interrupt_interface
//
// Sits between the core-local interruptor and the commit stage. It builds
// the architectural mip value from the software and timer request levels
// and from a synchronised copy of the asynchronous external request line.
// mip is masked with mie and gated by mstatus.MIE. One interrupt is chosen
// by fixed priority, MEI > MSI > MTI. The chosen interrupt is offered to
// commit with a level request / acknowledge handshake, and its cause is
// held stable until commit takes it.
//
// Parameters
//   EXT_SYNC_STAGES  flop stages on the external request line (>= 2)
//   REG_DATA_WIDTH   global define, CSR data width (default 32)
//
// Ports
//   clk                          clock
//   rst                          synchronous, active-high reset
//   all_intif_int_software_req   software interrupt level (msip[0])
//   all_intif_int_timer_req      timer interrupt level (mtime >= mtimecmp)
//   all_intif_int_ext_req        external interrupt level, asynchronous
//   csr_intif_mie_data           current mie CSR
//   csr_intif_mstatus_data       current mstatus CSR, bit 3 = MIE
//   intif_csr_mip_data           registered mip value for CSR reads
//   intif_commit_has_interrupt   interrupt request to the commit stage
//   intif_commit_mcause_data     mcause value for the requested interrupt
//   commit_intif_ack             commit has taken the interrupt this cycle
// ---------------------------------------------------------------------------
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module interrupt_interface #(
  parameter int EXT_SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       all_intif_int_software_req,
  input  logic                       all_intif_int_timer_req,
  input  logic                       all_intif_int_ext_req,
  input  logic [`REG_DATA_WIDTH-1:0] csr_intif_mie_data,
  input  logic [`REG_DATA_WIDTH-1:0] csr_intif_mstatus_data,
  output logic [`REG_DATA_WIDTH-1:0] intif_csr_mip_data,
  output logic                       intif_commit_has_interrupt,
  output logic [`REG_DATA_WIDTH-1:0] intif_commit_mcause_data,
  input  logic                       commit_intif_ack
);

  localparam int W = `REG_DATA_WIDTH;

  // Bit positions in mip / mie. They double as the mcause exception codes.
  localparam int MSI_BIT = 3;
  localparam int MTI_BIT = 7;
  localparam int MEI_BIT = 11;
  localparam int MSTATUS_MIE_BIT = 3;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // An interrupt cause has the top bit set and the exception code in [3:0].
  // Every other bit is zero.
  function automatic logic [W-1:0] make_mcause(input logic [3:0] code);
    logic [W-1:0] value;
    value        = '0;
    value[W-1]   = 1'b1;
    value[3:0]   = code;
    return value;
  endfunction

  // -------------------------------------------------------------------------
  // External request synchroniser. Stage 0 samples the asynchronous line.
  // Only the last stage is used downstream.
  // -------------------------------------------------------------------------
  logic [EXT_SYNC_STAGES-1:0] ext_sync_q;
  logic                       ext_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_sync_q <= '0;
    end else begin
      ext_sync_q <= {ext_sync_q[EXT_SYNC_STAGES-2:0], all_intif_int_ext_req};
    end
  end

  assign ext_sync = ext_sync_q[EXT_SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // mip follows the source levels with one cycle of delay. No bit is sticky,
  // so a source clears its own bit by dropping its request.
  // -------------------------------------------------------------------------
  logic [W-1:0] mip_d;
  logic [W-1:0] mip_q;

  always_comb begin
    mip_d          = '0;
    mip_d[MSI_BIT] = all_intif_int_software_req;
    mip_d[MTI_BIT] = all_intif_int_timer_req;
    mip_d[MEI_BIT] = ext_sync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mip_q <= '0;
    end else begin
      mip_q <= mip_d;
    end
  end

  assign intif_csr_mip_data = mip_q;

  // -------------------------------------------------------------------------
  // Masking and priority selection.
  // -------------------------------------------------------------------------
  logic       pend_msi;
  logic       pend_mti;
  logic       pend_mei;
  logic       enabled;
  logic       fire;
  logic [3:0] win_code;

  assign pend_msi = mip_q[MSI_BIT] & csr_intif_mie_data[MSI_BIT];
  assign pend_mti = mip_q[MTI_BIT] & csr_intif_mie_data[MTI_BIT];
  assign pend_mei = mip_q[MEI_BIT] & csr_intif_mie_data[MEI_BIT];
  assign enabled  = csr_intif_mstatus_data[MSTATUS_MIE_BIT];
  assign fire     = enabled & (pend_mei | pend_msi | pend_mti);

  always_comb begin
    win_code = CODE_MTI;
    if (pend_mei) begin
      win_code = CODE_MEI;
    end else if (pend_msi) begin
      win_code = CODE_MSI;
    end
  end

  // The remaining CSR bits have no meaning to this block.
  logic unused_csr_bits;
  assign unused_csr_bits = ^{csr_intif_mie_data[W-1:MEI_BIT+1],
                             csr_intif_mie_data[MEI_BIT-1:MTI_BIT+1],
                             csr_intif_mie_data[MTI_BIT-1:MSI_BIT+1],
                             csr_intif_mie_data[MSI_BIT-1:0],
                             csr_intif_mstatus_data[W-1:MSTATUS_MIE_BIT+1],
                             csr_intif_mstatus_data[MSTATUS_MIE_BIT-1:0]};

  // -------------------------------------------------------------------------
  // Request / acknowledge FSM.
  // -------------------------------------------------------------------------
  state_t       state_q;
  state_t       state_d;
  logic [3:0]   sel_q;
  logic [3:0]   sel_d;
  logic [W-1:0] mcause_q;
  logic [W-1:0] mcause_d;
  logic         has_int_q;
  logic         has_int_d;
  logic         sel_pending;

  // This asks whether the interrupt being offered is still pending. Priority
  // is not re-evaluated while a request is out, so only the latched source
  // counts.
  always_comb begin
    sel_pending = 1'b0;
    case (sel_q)
      CODE_MEI: sel_pending = pend_mei;
      CODE_MSI: sel_pending = pend_msi;
      CODE_MTI: sel_pending = pend_mti;
      default:  sel_pending = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      mcause_q  <= '0;
      has_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      mcause_q  <= mcause_d;
      has_int_q <= has_int_d;
    end
  end

  // If ack and withdraw happen in the same cycle, the ack is checked first.
  // Commit has already taken the interrupt, so this counts as a normal take.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    mcause_d  = mcause_q;
    has_int_d = has_int_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          sel_d     = win_code;
          mcause_d  = make_mcause(win_code);
          has_int_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (commit_intif_ack) begin
          has_int_d = 1'b0;
          state_d   = IDLE;
        end else if (!enabled || !sel_pending) begin
          has_int_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        has_int_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  assign intif_commit_has_interrupt = has_int_q;
  assign intif_commit_mcause_data   = mcause_q;

endmodule

// File: tb/tb_interrupt_interface.sv
// ---------------------------------------------------------------------------
// tb_interrupt_interface
//
// Self-checking bench for interrupt_interface. A behavioural model predicts
// mip, the request level and mcause. One process compares the DUT against
// that model on every falling edge. Directed scenarios with literal
// expectations come first, followed by randomised traffic.
// ---------------------------------------------------------------------------
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module tb_interrupt_interface;

  localparam int W = `REG_DATA_WIDTH;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         sw_req;
  logic         tmr_req;
  logic         ext_req;
  logic [W-1:0] mie;
  logic [W-1:0] mstatus;
  logic [W-1:0] mip;
  logic         has_int;
  logic [W-1:0] mcause;
  logic         ack;

  int tests    = 0;
  int failures = 0;

  interrupt_interface #(.EXT_SYNC_STAGES(N)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .all_intif_int_software_req (sw_req),
    .all_intif_int_timer_req    (tmr_req),
    .all_intif_int_ext_req      (ext_req),
    .csr_intif_mie_data         (mie),
    .csr_intif_mstatus_data     (mstatus),
    .intif_csr_mip_data         (mip),
    .intif_commit_has_interrupt (has_int),
    .intif_commit_mcause_data   (mcause),
    .commit_intif_ack           (ack)
  );

  always #5 clk = ~clk;

  // The model tracks the mip contents and whether a request is outstanding,
  // along with its code and cause. ext_hist holds the last N external
  // samples, with the oldest at the front.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_mip;
  logic [W-1:0] m_cause;
  bit           m_has;
  int           m_sel;
  bit           ext_hist[$];

  function automatic int pick(input logic [W-1:0] p);
    if (p[11]) return 11;
    if (p[3])  return 3;
    if (p[7])  return 7;
    return -1;
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] pend;
    if (rst) begin
      m_valid  = 1'b1;
      m_mip    = '0;
      m_cause  = '0;
      m_has    = 1'b0;
      m_sel    = 0;
      ext_hist = {};
      for (int i = 0; i < N; i++) ext_hist.push_back(1'b0);
    end else if (m_valid) begin
      pend = m_mip & mie;
      if (m_has) begin
        if (ack || !(mstatus[3] && pend[m_sel])) m_has = 1'b0;
      end else if (mstatus[3] && pick(pend) >= 0) begin
        m_sel          = pick(pend);
        m_has          = 1'b1;
        m_cause        = '0;
        m_cause[W-1]   = 1'b1;
        m_cause[3:0]   = m_sel[3:0];
      end
      m_mip     = '0;
      m_mip[3]  = sw_req;
      m_mip[7]  = tmr_req;
      m_mip[11] = ext_hist.pop_front();
      ext_hist.push_back(ext_req);
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] got,
                             input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_mip", mip, m_mip);
      checkOutput("model_has_interrupt", {{(W-1){1'b0}}, has_int}, {{(W-1){1'b0}}, m_has});
      checkOutput("model_mcause", mcause, m_cause);
    end
  end

  // This task drives one cycle of inputs and returns just after the next
  // rising edge, which leaves the outputs settled for checking.
  task automatic applyStimulus(input bit r, input bit sw, input bit tm, input bit ex,
                               input logic [W-1:0] mie_v, input logic [W-1:0] ms_v,
                               input bit a);
    rst     = r;
    sw_req  = sw;
    tmr_req = tm;
    ext_req = ex;
    mie     = mie_v;
    mstatus = ms_v;
    ack     = a;
    @(posedge clk);
    #1;
  endtask

  task automatic expectHas(input string name, input bit exp);
    checkOutput(name, {{(W-1){1'b0}}, has_int}, {{(W-1){1'b0}}, exp});
  endtask

  initial begin
    logic [W-1:0] rmie;
    logic [W-1:0] rms;

    // Reset values
    applyStimulus(1, 0, 0, 0, 'h888, 'h8, 0);
    applyStimulus(1, 0, 0, 0, 'h888, 'h8, 0);
    checkOutput("reset_mip", mip, 32'h0);
    expectHas("reset_has", 1'b0);
    checkOutput("reset_mcause", mcause, 32'h0);
    repeat (3) applyStimulus(0, 0, 0, 0, 'h888, 'h8, 0);

    // The timer request: mip one cycle later, the request two cycles later,
    // held until ack
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    checkOutput("timer_mip", mip, 32'h80);
    expectHas("timer_not_yet", 1'b0);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("timer_has", 1'b1);
    checkOutput("timer_mcause", mcause, 32'h80000007);
    repeat (3) applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("timer_held", 1'b1);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 1);
    expectHas("timer_acked", 1'b0);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("timer_rerequest", 1'b1);
    applyStimulus(0, 0, 0, 0, 'h888, 'h8, 1);
    expectHas("timer_ack_cleared", 1'b0);
    applyStimulus(0, 0, 0, 0, 'h888, 'h8, 0);
    expectHas("timer_stays_idle", 1'b0);
    checkOutput("timer_mip_clear", mip, 32'h0);

    // Priority when all three sources are raised together
    repeat (4) applyStimulus(0, 1, 1, 1, 'h888, 'h0, 0);
    checkOutput("all_mip", mip, 32'h888);
    expectHas("all_mie_off", 1'b0);
    applyStimulus(0, 1, 1, 1, 'h888, 'h8, 0);
    expectHas("all_has", 1'b1);
    checkOutput("prio_mei", mcause, 32'h8000000B);
    applyStimulus(0, 1, 1, 0, 'h888, 'h0, 0);
    expectHas("mei_withdrawn", 1'b0);
    repeat (3) applyStimulus(0, 1, 1, 0, 'h888, 'h0, 0);
    checkOutput("ext_dropped_mip", mip, 32'h88);
    applyStimulus(0, 1, 1, 0, 'h888, 'h8, 0);
    checkOutput("prio_msi", mcause, 32'h80000003);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 1);
    expectHas("msi_acked", 1'b0);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("mti_after_msi", 1'b1);
    checkOutput("prio_mti", mcause, 32'h80000007);

    // Clearing mstatus.MIE withdraws the request, and setting it again
    // brings the request back
    applyStimulus(0, 0, 1, 0, 'h888, 'h0, 0);
    expectHas("mie_cleared_withdraw", 1'b0);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("mie_restored", 1'b1);
    checkOutput("mie_restored_cause", mcause, 32'h80000007);

    // A higher-priority source arriving during a request waits for the ack
    repeat (2) applyStimulus(0, 1, 1, 0, 'h888, 'h8, 0);
    checkOutput("no_preempt", mcause, 32'h80000007);
    applyStimulus(0, 1, 1, 0, 'h888, 'h8, 1);
    expectHas("preempt_gap", 1'b0);
    checkOutput("mcause_holds_idle", mcause, 32'h80000007);
    applyStimulus(0, 1, 1, 0, 'h888, 'h8, 0);
    checkOutput("msi_after_gap", mcause, 32'h80000003);

    // With mie = 0 nothing is requested, and an ack while idle does nothing
    repeat (5) applyStimulus(0, 1, 1, 1, 'h0, 'h8, 0);
    checkOutput("mie0_mip", mip, 32'h888);
    expectHas("mie0_no_req", 1'b0);
    applyStimulus(0, 1, 1, 1, 'h0, 'h8, 1);
    applyStimulus(0, 1, 1, 1, 'h0, 'h8, 0);
    expectHas("idle_ack_ignored", 1'b0);
    checkOutput("idle_ack_mcause", mcause, 32'h80000003);

    // Reset during an outstanding request
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    checkOutput("pre_reset_cause", mcause, 32'h8000000B);
    applyStimulus(1, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("reset_mid_has", 1'b0);
    checkOutput("reset_mid_mip", mip, 32'h0);
    checkOutput("reset_mid_mcause", mcause, 32'h0);

    // Ack and withdraw in the same cycle count as a single take
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    applyStimulus(0, 0, 1, 0, 'h888, 'h8, 0);
    expectHas("ackwd_has", 1'b1);
    applyStimulus(0, 0, 1, 0, 'h888, 'h0, 1);
    expectHas("ackwd_taken", 1'b0);
    applyStimulus(0, 0, 1, 0, 'h888, 'h0, 0);
    expectHas("ackwd_idle", 1'b0);

    // Randomised traffic, checked against the model by the compare process
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rmie = 'h888;
        1:       rmie = '0;
        default: rmie = $urandom();
      endcase
      rms    = $urandom();
      rms[3] = ($urandom_range(0, 7) != 0);
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 2) != 0, rmie, rms,
                    $urandom_range(0, 3) == 0);
    end
    applyStimulus(0, 0, 0, 0, 'h0, 'h0, 0);
    applyStimulus(0, 0, 0, 0, 'h0, 'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
